// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM of the multi-cycle MIPS-subset core, with memory timeout trap and retire counter
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             alu_zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             ir_write_o,
  output logic             i_or_d_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             trap_o,
  output logic             bus_err_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                         ADDR = 4'd4, MEM_RD = 4'd5, MEM_WR = 4'd6, WB_MEM = 4'd7,
                         WB_ALU = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, TRAP = 4'd11;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [3:0] state, nxt;
  logic [TW-1:0] tcnt;
  logic mem_wait, tmo, retire, is_beq, is_bne;
  assign state_o = state;
  assign is_beq = instr_op_i == 6'b000100;
  assign is_bne = instr_op_i == 6'b000101;
  assign mem_wait = state == FETCH || state == MEM_RD || state == MEM_WR;
  assign tmo = mem_wait && !mem_ready_i && tcnt == TW'(MEM_TIMEOUT - 1);
  assign retire = nxt == FETCH && (state == WB_ALU || state == WB_MEM || state == MEM_WR ||
                                   state == BRANCH || state == JUMP);
  always_comb begin
    nxt = state;
    pc_write_o = 1'b0;
    pc_src_o = 2'd0;
    ir_write_o = 1'b0;
    i_or_d_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    reg_write_o = 1'b0;
    reg_dst_o = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 2'd0;
    alu_op_o = 3'd0;
    case (state)
      FETCH: begin
        mem_req_o = 1'b1;
        alu_src_b_o = 2'd1;
        alu_op_o = 3'd7;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
        nxt = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b_o = 2'd3;
        alu_op_o = 3'd7;
        case (instr_op_i)
          6'b000000: nxt = EXEC_R;
          6'b001000, 6'b001011, 6'b001111, 6'b001101: nxt = EXEC_I;
          6'b100011, 6'b101011: nxt = ADDR;
          6'b000100, 6'b000101: nxt = BRANCH;
          6'b000010: nxt = JUMP;
          default: nxt = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        nxt = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o = instr_op_i == 6'b001011 ? 3'd2 :
                   instr_op_i == 6'b001111 ? 3'd4 :
                   instr_op_i == 6'b001101 ? 3'd5 : 3'd1;
        nxt = WB_ALU;
      end
      WB_ALU: begin
        reg_write_o = 1'b1;
        reg_dst_o = instr_op_i == 6'b000000;
        nxt = FETCH;
      end
      ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o = 3'd7;
        nxt = instr_op_i == 6'b100011 ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req_o = 1'b1;
        i_or_d_o = 1'b1;
        nxt = mem_ready_i ? WB_MEM : MEM_RD;
      end
      WB_MEM: begin
        reg_write_o = 1'b1;
        mem_to_reg_o = 1'b1;
        nxt = FETCH;
      end
      MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o = 1'b1;
        i_or_d_o = 1'b1;
        nxt = mem_ready_i ? FETCH : MEM_WR;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        pc_src_o = 2'd1;
        alu_op_o = is_beq ? 3'd3 : 3'd6;
        pc_write_o = (is_beq && alu_zero_i) || (is_bne && !alu_zero_i);
        nxt = FETCH;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o = 2'd2;
        nxt = FETCH;
      end
      TRAP: nxt = TRAP;
      default: nxt = FETCH;
    endcase
    if (tmo) nxt = TRAP;
    // reset must block any write strobe immediately, not just after the next edge
    if (rst_i) begin
      pc_write_o = 1'b0;
      ir_write_o = 1'b0;
      reg_write_o = 1'b0;
      mem_we_o = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FETCH;
      tcnt <= '0;
      retired_o <= '0;
      trap_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state <= nxt;
      tcnt <= (nxt != state || mem_ready_i || !mem_wait) ? '0 : tcnt + 1'b1;
      if (retire) retired_o <= retired_o + 1'b1;
      if (state == DECODE && nxt == TRAP) trap_o <= 1'b1;
      if (tmo) bus_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: vector table plus directed corner sequences for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [5:0] instr_op_i = 6'd0;
  logic alu_zero_i = 1'b0, mem_ready_i = 1'b0;
  logic pc_write_o, ir_write_o, i_or_d_o, mem_req_o, mem_we_o, reg_write_o, reg_dst_o;
  logic mem_to_reg_o, alu_src_a_o, trap_o, bus_err_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic [31:0] retired_o;
  logic [15:0] ctrl;
  int errors = 0, checks = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .alu_zero_i(alu_zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .trap_o(trap_o), .bus_err_o(bus_err_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  assign ctrl = {pc_write_o, pc_src_o, ir_write_o, i_or_d_o, mem_req_o, mem_we_o, reg_write_o,
                 reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o};

  typedef struct {
    logic [5:0] op;
    logic rdy;
    logic z;
    logic [3:0] st;
    logic [15:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] c(input int pw, ps, irw, iod, req, we, rw, rd, m2r, sa, sb, op);
    return {pw[0], ps[1:0], irw[0], iod[0], req[0], we[0], rw[0], rd[0], m2r[0], sa[0], sb[1:0], op[2:0]};
  endfunction

  function automatic vec_t mk(input int op, rdy, z, st, input logic [15:0] ctl, input int ret);
    vec_t v;
    v.op = op[5:0];
    v.rdy = rdy[0];
    v.z = z[0];
    v.st = st[3:0];
    v.ctl = ctl;
    v.ret = ret;
    return v;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    mem_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f_rdy, f_wait, dec, adr, mrd, exi, wbi;
    f_rdy = c(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 7);
    f_wait = c(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 7);
    dec = c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7);
    adr = c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 7);
    mrd = c(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    wbi = c(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    exi = c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    // R-type
    q.push_back(mk(0, 1, 0, 0, f_rdy, 0));
    q.push_back(mk(0, 1, 0, 1, dec, 0));
    q.push_back(mk(0, 1, 0, 2, c(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0));
    q.push_back(mk(0, 1, 0, 8, c(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 0));
    // LW with two wait cycles
    q.push_back(mk('b100011, 1, 0, 0, f_rdy, 1));
    q.push_back(mk('b100011, 1, 0, 1, dec, 1));
    q.push_back(mk('b100011, 1, 0, 4, adr, 1));
    q.push_back(mk('b100011, 0, 0, 5, mrd, 1));
    q.push_back(mk('b100011, 0, 0, 5, mrd, 1));
    q.push_back(mk('b100011, 1, 0, 5, mrd, 1));
    q.push_back(mk('b100011, 1, 0, 7, c(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), 1));
    // BEQ taken, BNE not taken
    q.push_back(mk('b000100, 1, 1, 0, f_rdy, 2));
    q.push_back(mk('b000100, 1, 1, 1, dec, 2));
    q.push_back(mk('b000100, 1, 1, 9, c(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3), 2));
    q.push_back(mk('b000101, 1, 1, 0, f_rdy, 3));
    q.push_back(mk('b000101, 1, 1, 1, dec, 3));
    q.push_back(mk('b000101, 1, 1, 9, c(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6), 3));
    // SW
    q.push_back(mk('b101011, 1, 0, 0, f_rdy, 4));
    q.push_back(mk('b101011, 1, 0, 1, dec, 4));
    q.push_back(mk('b101011, 1, 0, 4, adr, 4));
    q.push_back(mk('b101011, 1, 0, 6, c(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), 4));
    // J with one fetch wait
    q.push_back(mk('b000010, 0, 0, 0, f_wait, 5));
    q.push_back(mk('b000010, 1, 0, 0, f_rdy, 5));
    q.push_back(mk('b000010, 1, 0, 1, dec, 5));
    q.push_back(mk('b000010, 1, 0, 10, c(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 5));
    // ADDI, ORI, SLTIU
    q.push_back(mk('b001000, 1, 0, 0, f_rdy, 6));
    q.push_back(mk('b001000, 1, 0, 1, dec, 6));
    q.push_back(mk('b001000, 1, 0, 3, exi | 16'd1, 6));
    q.push_back(mk('b001000, 1, 0, 8, wbi, 6));
    q.push_back(mk('b001101, 1, 0, 0, f_rdy, 7));
    q.push_back(mk('b001101, 1, 0, 1, dec, 7));
    q.push_back(mk('b001101, 1, 0, 3, exi | 16'd5, 7));
    q.push_back(mk('b001101, 1, 0, 8, wbi, 7));
    q.push_back(mk('b001011, 1, 0, 0, f_rdy, 8));
    q.push_back(mk('b001011, 1, 0, 1, dec, 8));
    q.push_back(mk('b001011, 1, 0, 3, exi | 16'd2, 8));
    q.push_back(mk('b001011, 1, 0, 8, wbi, 8));
    q.push_back(mk(0, 0, 0, 0, f_wait, 9));

    rst_i = 1'b1;
    #2;
    chk("reset state", 32'(state_o), 32'd0);
    chk("reset retired", retired_o, 32'd0);
    chk("reset flags", 32'({trap_o, bus_err_o}), 32'd0);
    do_reset();
    foreach (q[i]) begin
      @(negedge clk_i);
      instr_op_i = q[i].op;
      mem_ready_i = q[i].rdy;
      alu_zero_i = q[i].z;
      #1;
      chk($sformatf("v%0d state", i), 32'(state_o), 32'(q[i].st));
      chk($sformatf("v%0d ctrl", i), 32'(ctrl), 32'(q[i].ctl));
      chk($sformatf("v%0d retired", i), retired_o, q[i].ret);
    end

    // illegal opcode trap is sticky until reset
    do_reset();
    instr_op_i = 6'b111111;
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ill decode", 32'(state_o), 32'd1);
    @(posedge clk_i); #1;
    chk("ill trap state", 32'(state_o), 32'd11);
    chk("ill trap flags", 32'({trap_o, bus_err_o}), 32'b10);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      mem_ready_i = k[0];
      #1;
      chk($sformatf("trap hold %0d", k), 32'({state_o, trap_o, mem_req_o, ctrl}),
          32'({4'd11, 1'b1, 1'b0, 16'd0}));
    end
    do_reset();
    #1;
    chk("trap cleared", 32'({state_o, trap_o}), 32'd0);

    // fetch timeout
    do_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("tmo pending", 32'({state_o, bus_err_o}), 32'd0);
    @(posedge clk_i); #1;
    chk("tmo state", 32'(state_o), 32'd11);
    chk("tmo flags", 32'({trap_o, bus_err_o}), 32'b01);
    chk("tmo no req", 32'(mem_req_o), 32'd0);

    // ready on the last allowed cycle wins
    do_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("late ready state", 32'(state_o), 32'd1);
    chk("late ready flag", 32'(bus_err_o), 32'd0);

    // async reset in the middle of a store
    do_reset();
    instr_op_i = 6'b000000;
    mem_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    instr_op_i = 6'b101011;
    repeat (3) @(posedge clk_i);
    #1;
    mem_ready_i = 1'b0;
    chk("sw state", 32'(state_o), 32'd6);
    chk("sw we", 32'(mem_we_o), 32'd1);
    chk("sw retired", retired_o, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst state", 32'(state_o), 32'd0);
    chk("arst we", 32'(mem_we_o), 32'd0);
    chk("arst retired", retired_o, 32'd0);
    mem_ready_i = 1'b1;
    #1;
    chk("arst enables", 32'({pc_write_o, ir_write_o, reg_write_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS-subset core.
- Sequences fetch, decode, execute, memory and writeback over several cycles, using one shared ALU and one shared memory port.
- Drives every datapath mux, enable and ALU-op select, and handshakes with the unified memory through a req/ready pair.
- Traps on illegal opcodes and on memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req_o may stay high without mem_ready_i before a bus-error trap.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk_i input 1: clock.
- rst_i input 1: reset. Asynchronous and active-high.
- instr_op_i input 6: opcode field from the instruction register.
- alu_zero_i input 1: ALU zero flag.
- mem_ready_i input 1: memory has completed the current request this cycle.
- pc_write_o output 1: PC load enable.
- pc_src_o output 2: PC source. 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- ir_write_o output 1: instruction register load enable.
- i_or_d_o output 1: memory address select. 0 = PC, 1 = ALUOut.
- mem_req_o output 1: memory request.
- mem_we_o output 1: memory write enable. Valid only while mem_req_o is high.
- reg_write_o output 1: register file write enable.
- reg_dst_o output 1: destination register select. 1 = rd, 0 = rt.
- mem_to_reg_o output 1: writeback source. 1 = MDR, 0 = ALUOut.
- alu_src_a_o output 1: ALU A operand. 0 = PC, 1 = rs.
- alu_src_b_o output 2: ALU B operand. 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- alu_op_o output 3: ALU op. 0 R_TYPE, 1 ADDI, 2 SLTIU, 3 BEQ, 4 LUI, 5 ORI, 6 BNE, 7 ADD.
- trap_o output 1: illegal opcode trap.
- bus_err_o output 1: memory timeout trap.
- state_o output 4: current state encoding.
- retired_o output CNT_W: retired-instruction count.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_ALU=8, BRANCH=9, JUMP=10, TRAP=11.
- Reset:
  - state = FETCH, retired_o = 0, timeout counter = 0.
  - All outputs not driven by the FETCH state decode are 0.
- Control outputs are combinational from state, except the items noted below, which are also gated by inputs. Any control not listed for a state is 0.
- FETCH:
  - Drives mem_req_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=7.
  - When mem_ready_i=1: ir_write_o=1, pc_write_o=1, pc_src_o=0, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE:
  - Computes the branch target: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=7.
  - Dispatch on instr_op_i:
    - 000000 → EXEC_R.
    - 001000, 001011, 001111, 001101 → EXEC_I.
    - 100011 (LW), 101011 (SW) → ADDR.
    - 000100, 000101 → BRANCH.
    - 000010 → JUMP.
    - anything else → TRAP.
- EXEC_R: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=0, then WB_ALU.
- EXEC_I:
  - alu_src_a_o=1, alu_src_b_o=2.
  - alu_op_o: ADDI=1, SLTIU=2, LUI=4, ORI=5.
  - Then WB_ALU.
- WB_ALU:
  - reg_write_o=1, mem_to_reg_o=0.
  - reg_dst_o=1 only when instr_op_i=000000.
  - Then FETCH.
- ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=7. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req_o=1, i_or_d_o=1. Holds until mem_ready_i, then WB_MEM.
- WB_MEM: reg_write_o=1, mem_to_reg_o=1, reg_dst_o=0, then FETCH.
- MEM_WR: mem_req_o=1, mem_we_o=1, i_or_d_o=1. Holds until mem_ready_i, then FETCH.
- BRANCH:
  - alu_src_a_o=1, alu_src_b_o=0, pc_src_o=1.
  - alu_op_o: 3 for BEQ, 6 for BNE.
  - pc_write_o = (BEQ & alu_zero_i) | (BNE & ~alu_zero_i), same cycle.
  - Then FETCH.
- JUMP: pc_write_o=1, pc_src_o=2, then FETCH.
- Retirement: retired_o increments by 1 on each transition into FETCH from WB_ALU, WB_MEM, MEM_WR, BRANCH or JUMP. It wraps modulo 2^CNT_W.
- Memory timeout:
  - The counter increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready_i=0.
  - It clears on mem_ready_i or on any state change.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready_i still 0, the next state is TRAP and bus_err_o is set.
  - If mem_ready_i arrives in that same cycle, the normal transition wins.
- TRAP:
  - Sticky until reset. All enables are 0 and mem_req_o=0.
  - trap_o=1 when entered from DECODE; bus_err_o=1 when entered via timeout. Both flags are registered.
- Asserting rst_i mid-instruction immediately forces FETCH and deasserts all enables. No partial writeback or PC update may occur after reset.

Test Plan:
- Reset released, mem_ready_i tied 1, opcode 000000 → states 0,1,2,8,0 over 4 cycles; reg_write_o=1 and reg_dst_o=1 in cycle 4; retired_o=1.
- LW (100011), mem_ready_i low for 2 cycles in MEM_RD → MEM_RD held 3 cycles, then WB_MEM with mem_to_reg_o=1; total 7 cycles; retired_o increments once.
- BEQ with alu_zero_i=1, then BNE with alu_zero_i=1 → pc_write_o=1, pc_src_o=1 for BEQ; pc_write_o=0 for BNE; both retire.
- Opcode 111111 → DECODE→TRAP; trap_o=1 held for 20 cycles with mem_req_o=0 until rst_i pulse.
- MEM_TIMEOUT=4, mem_ready_i never asserts in FETCH → bus_err_o=1 and state_o=11 after 4 FETCH cycles; mem_ready_i on the 4th cycle instead → DECODE with no error.
- rst_i asserted mid-cycle during MEM_WR → state_o=0 and mem_we_o=0 asynchronously; retired_o=0.
